// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port RAM arbiter: FSM state encoding and port indices.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  function automatic logic other_port(input logic p);
    return ~p;
  endfunction

endpackage

// File: rtl/mem_arb_if.sv
// Client handshakes and RAM pins of the arbiter. The slave modport is the arbiter's view;
// the master modport is the clients and RAM together.
interface mem_arb_if #(
  parameter int addr_width = 6,
  parameter int bus_width  = 14
);
  logic                  r0_req;
  logic                  r0_we;
  logic                  r0_lock;
  logic [addr_width-1:0] r0_addr;
  logic [bus_width-1:0]  r0_wdata;
  logic                  r0_gnt;
  logic                  r0_rvalid;
  logic [bus_width-1:0]  r0_rdata;

  logic                  r1_req;
  logic                  r1_we;
  logic                  r1_lock;
  logic [addr_width-1:0] r1_addr;
  logic [bus_width-1:0]  r1_wdata;
  logic                  r1_gnt;
  logic                  r1_rvalid;
  logic [bus_width-1:0]  r1_rdata;

  logic                  mem_en;
  logic                  mem_cs;
  logic [addr_width-1:0] mem_addr;
  logic [bus_width-1:0]  mem_din;
  logic [bus_width-1:0]  mem_dout;

  modport slave (
    input  r0_req, r0_we, r0_lock, r0_addr, r0_wdata,
    output r0_gnt, r0_rvalid, r0_rdata,
    input  r1_req, r1_we, r1_lock, r1_addr, r1_wdata,
    output r1_gnt, r1_rvalid, r1_rdata,
    output mem_en, mem_cs, mem_addr, mem_din,
    input  mem_dout
  );

  modport master (
    output r0_req, r0_we, r0_lock, r0_addr, r0_wdata,
    input  r0_gnt, r0_rvalid, r0_rdata,
    output r1_req, r1_we, r1_lock, r1_addr, r1_wdata,
    input  r1_gnt, r1_rvalid, r1_rdata,
    input  mem_en, mem_cs, mem_addr, mem_din,
    output mem_dout
  );
endinterface

// File: rtl/mem_arb_rr.sv
// Two-way round-robin pick: a lone request wins, contention goes to the port rr_ptr names.
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       rr_ptr,
  output logic [1:0] gnt
);

  assign gnt[0] = req[0] & (~req[1] | (rr_ptr == PORT0));
  assign gnt[1] = req[1] & (~req[0] | (rr_ptr == PORT1));

endmodule

// File: rtl/mem_arb.sv
// Round-robin arbiter sharing one single-port synchronous RAM between two clients.
// Define MEM_ARB_LOCK_EN to build the bounded burst lock (OWN states, burst_cnt).
//
// state | meaning
// IDLE  | no owner, round-robin pick between requesters
// OWN0  | port 0 holds the RAM for a locked burst
// OWN1  | port 1 holds the RAM for a locked burst
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int addr_width = 6,
  parameter int bus_width  = 14,
  parameter int max_burst  = 4
) (
  input  logic     clk,
  input  logic     rstn,
  mem_arb_if.slave bus
);

  logic [1:0] req;
  logic [1:0] rr_gnt;
  logic [1:0] gnt;
  logic [1:0] gnt_q;
  logic [1:0] rvalid;
  logic       rr_ptr;
  logic       ptr_nxt;

  assign req = {bus.r1_req, bus.r0_req};

  mem_arb_rr u_rr (
    .req   (req),
    .rr_ptr(rr_ptr),
    .gnt   (rr_gnt)
  );

`ifdef MEM_ARB_LOCK_EN
  localparam int cnt_w = $clog2(max_burst + 1);
  localparam logic [cnt_w-1:0] cnt_max = cnt_w'(max_burst);

  arb_state_t       state;
  arb_state_t       state_nxt;
  logic [cnt_w-1:0] burst_cnt;
  logic [cnt_w-1:0] cnt_nxt;
  logic [cnt_w-1:0] cnt_inc;
  logic [1:0]       lock;
  logic             own;

  assign lock    = {bus.r1_lock, bus.r0_lock};
  assign own     = (state == IDLE) ? rr_gnt[1] : (state == OWN1);
  assign cnt_inc = (burst_cnt == cnt_max) ? burst_cnt : burst_cnt + cnt_w'(1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      rr_ptr    <= PORT0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= ptr_nxt;
      burst_cnt <= cnt_nxt;
    end
  end

  always_comb begin
    gnt       = 2'b00;
    state_nxt = state;
    ptr_nxt   = rr_ptr;
    cnt_nxt   = burst_cnt;
    case (state)
      IDLE: begin
        gnt = rr_gnt;
        if (|rr_gnt) begin
          ptr_nxt = other_port(own);
          if (lock[own] && (max_burst > 1)) begin
            state_nxt = own ? OWN1 : OWN0;
            cnt_nxt   = cnt_w'(1);
          end
        end
      end
      default: begin
        // The owner is exclusive; the other port waits even while the owner idles a cycle out.
        gnt[own] = req[own];
        if (req[own] && lock[own] && (cnt_inc != cnt_max)) begin
          cnt_nxt = cnt_inc;
        end else begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          ptr_nxt   = other_port(own);
        end
      end
    endcase
  end
`else
  logic [33:0] unused_cfg;
  assign unused_cfg = {bus.r0_lock, bus.r1_lock, 32'(max_burst)};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rr_ptr <= PORT0;
    else       rr_ptr <= ptr_nxt;
  end

  always_comb begin
    gnt     = rr_gnt;
    ptr_nxt = rr_ptr;
    if (|rr_gnt) ptr_nxt = other_port(rr_gnt[1]);
  end
`endif

  // Grants are held off while in reset so the RAM is never touched.
  assign gnt_q = rstn ? gnt : 2'b00;

  assign bus.r0_gnt   = gnt_q[0];
  assign bus.r1_gnt   = gnt_q[1];
  assign bus.mem_cs   = |gnt_q;
  assign bus.mem_en   = (gnt_q[0] & bus.r0_we) | (gnt_q[1] & bus.r1_we);
  assign bus.mem_addr = gnt_q[1] ? bus.r1_addr  :
                        gnt_q[0] ? bus.r0_addr  : {addr_width{1'b0}};
  assign bus.mem_din  = gnt_q[1] ? bus.r1_wdata :
                        gnt_q[0] ? bus.r0_wdata : {bus_width{1'b0}};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rvalid <= 2'b00;
    else       rvalid <= {gnt_q[1] & ~bus.r1_we, gnt_q[0] & ~bus.r0_we};
  end

  assign bus.r0_rvalid = rvalid[0];
  assign bus.r1_rvalid = rvalid[1];
  assign bus.r0_rdata  = rvalid[0] ? bus.mem_dout : {bus_width{1'b0}};
  assign bus.r1_rdata  = rvalid[1] ? bus.mem_dout : {bus_width{1'b0}};

endmodule

// File: tb/tb_mem_arb.sv
// Bench for mem_arb: directed stimulus pushes expected grants/read returns into queues,
// a negedge monitor pops and compares whenever the arbiter grants or returns read data.
module tb_mem_arb;

  typedef struct {
    logic        port;
    logic        we;
    logic [5:0]  addr;
    logic [13:0] din;
  } g_t;

  typedef struct {
    logic        port;
    logic [13:0] data;
  } r_t;

  logic clk;
  logic rstn;
  int   checks;
  int   failures;

  g_t gq[$];
  r_t rq[$];
  g_t ge;
  r_t re;

  logic [13:0] ram [64];
  bit          ram_init;

  mem_arb_if #(.addr_width(6), .bus_width(14)) bus ();

  mem_arb #(.addr_width(6), .bus_width(14), .max_burst(4)) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM model: registered address, one-cycle read latency, preloaded with 0x2000|addr.
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 64; i++) ram[i] <= 14'h2000 | 14'(i);
      ram_init <= 1'b1;
    end else if (bus.mem_cs) begin
      if (bus.mem_en) ram[bus.mem_addr] <= bus.mem_din;
      else            bus.mem_dout <= ram[bus.mem_addr];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.r0_gnt || bus.r1_gnt) begin
      if (gq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_gnt: got r1/r0=%0b%0b expected none", bus.r1_gnt, bus.r0_gnt);
      end else begin
        ge = gq.pop_front();
        chk("gnt", 32'({bus.r1_gnt, bus.r0_gnt}), ge.port ? 32'd2 : 32'd1);
        chk("mem_cs", 32'(bus.mem_cs), 32'd1);
        chk("mem_en", 32'(bus.mem_en), 32'(ge.we));
        chk("mem_addr", 32'(bus.mem_addr), 32'(ge.addr));
        chk("mem_din", 32'(bus.mem_din), 32'(ge.din));
      end
    end else begin
      chk("mem_idle", 32'({bus.mem_cs, bus.mem_en, bus.mem_addr, bus.mem_din}), 32'd0);
    end

    if (bus.r0_rvalid || bus.r1_rvalid) begin
      if (rq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rvalid: got r1/r0=%0b%0b expected none", bus.r1_rvalid, bus.r0_rvalid);
      end else begin
        re = rq.pop_front();
        chk("rvalid", 32'({bus.r1_rvalid, bus.r0_rvalid}), re.port ? 32'd2 : 32'd1);
        chk("rdata", 32'(re.port ? bus.r1_rdata : bus.r0_rdata), 32'(re.data));
        chk("rdata_other", 32'(re.port ? bus.r0_rdata : bus.r1_rdata), 32'd0);
      end
    end else begin
      chk("rdata_idle", 32'({bus.r1_rdata, bus.r0_rdata}), 32'd0);
    end
  end

  task automatic drv0(input logic q, input logic w, input logic l, input logic [5:0] a, input logic [13:0] d);
    bus.r0_req = q; bus.r0_we = w; bus.r0_lock = l; bus.r0_addr = a; bus.r0_wdata = d;
  endtask

  task automatic drv1(input logic q, input logic w, input logic l, input logic [5:0] a, input logic [13:0] d);
    bus.r1_req = q; bus.r1_we = w; bus.r1_lock = l; bus.r1_addr = a; bus.r1_wdata = d;
  endtask

  task automatic exp_g(input logic p, input logic w, input logic [5:0] a, input logic [13:0] d,
                       input logic [13:0] rd, input bit ret);
    gq.push_back('{port: p, we: w, addr: a, din: d});
    if (!w && ret) rq.push_back('{port: p, data: rd});
  endtask

  task automatic idle_all();
    drv0(1'b0, 1'b0, 1'b0, 6'd0, 14'd0);
    drv1(1'b0, 1'b0, 1'b0, 6'd0, 14'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, 32'({bus.r1_gnt, bus.r0_gnt}), 32'd0);
    chk({tag, "_rvalid"}, 32'({bus.r1_rvalid, bus.r0_rvalid}), 32'd0);
    chk({tag, "_rdata"}, 32'({bus.r1_rdata, bus.r0_rdata}), 32'd0);
    chk({tag, "_mem"}, 32'({bus.mem_cs, bus.mem_en, bus.mem_addr, bus.mem_din}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks   = 0;
    failures = 0;
    rstn     = 1'b0;
    bus.mem_dout = 14'd0;
    // Requests held high in reset must not produce grants.
    drv0(1'b1, 1'b0, 1'b0, 6'd3, 14'd0);
    drv1(1'b1, 1'b0, 1'b0, 6'd4, 14'd0);
    @(negedge clk);
    #1;
    chk_all_zero("reset");
    step();
    idle_all();
    rstn = 1'b1;
    step();

    // Single port: write then read back through the RAM.
    drv0(1'b1, 1'b1, 1'b0, 6'd3, 14'h155);
    exp_g(1'b0, 1'b1, 6'd3, 14'h155, 14'd0, 1'b0);
    step();
    drv0(1'b1, 1'b0, 1'b0, 6'd3, 14'd0);
    exp_g(1'b0, 1'b0, 6'd3, 14'd0, 14'h155, 1'b1);
    step();
    idle_all();
    step();

    // r1 alone moves the pointer back to r0, then contention alternates.
    drv1(1'b1, 1'b1, 1'b0, 6'd9, 14'h2AB);
    exp_g(1'b1, 1'b1, 6'd9, 14'h2AB, 14'd0, 1'b0);
    step();
    drv0(1'b1, 1'b0, 1'b0, 6'd5, 14'd0);
    drv1(1'b1, 1'b0, 1'b0, 6'd9, 14'd0);
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) exp_g(1'b0, 1'b0, 6'd5, 14'd0, 14'h2005, 1'b1);
      else            exp_g(1'b1, 1'b0, 6'd9, 14'd0, 14'h2AB, 1'b1);
      step();
    end
    idle_all();
    step();

`ifdef MEM_ARB_LOCK_EN
    // Pointer to r1, then r1 locked burst against a competing r0: four r1 grants, then r0.
    drv0(1'b1, 1'b1, 1'b0, 6'd10, 14'h0AA);
    exp_g(1'b0, 1'b1, 6'd10, 14'h0AA, 14'd0, 1'b0);
    step();
    for (int i = 0; i < 4; i++) begin
      drv0(1'b1, 1'b0, 1'b0, 6'd10, 14'd0);
      drv1(1'b1, 1'b1, 1'b1, 6'(20 + i), 14'(14'h300 + i));
      exp_g(1'b1, 1'b1, 6'(20 + i), 14'(14'h300 + i), 14'd0, 1'b0);
      step();
    end
    drv1(1'b1, 1'b1, 1'b1, 6'd24, 14'h304);
    exp_g(1'b0, 1'b0, 6'd10, 14'd0, 14'h0AA, 1'b1);
    step();
    idle_all();
    step();

    // r0 locks for two grants, releases on the third while r1 waits; r1 follows immediately.
    drv0(1'b1, 1'b1, 1'b1, 6'd30, 14'h010);
    exp_g(1'b0, 1'b1, 6'd30, 14'h010, 14'd0, 1'b0);
    step();
    drv0(1'b1, 1'b1, 1'b1, 6'd31, 14'h011);
    drv1(1'b1, 1'b1, 1'b0, 6'd40, 14'h040);
    exp_g(1'b0, 1'b1, 6'd31, 14'h011, 14'd0, 1'b0);
    step();
    drv0(1'b1, 1'b1, 1'b0, 6'd32, 14'h012);
    exp_g(1'b0, 1'b1, 6'd32, 14'h012, 14'd0, 1'b0);
    step();
    drv0(1'b1, 1'b1, 1'b0, 6'd33, 14'h013);
    exp_g(1'b1, 1'b1, 6'd40, 14'h040, 14'd0, 1'b0);
    step();
    idle_all();
    step();
`else
    // Lock is ignored: both locked requesters still alternate every cycle.
    for (int i = 0; i < 4; i++) begin
      drv0(1'b1, 1'b1, 1'b1, 6'(40 + i), 14'(14'h050 + i));
      drv1(1'b1, 1'b1, 1'b1, 6'(48 + i), 14'(14'h060 + i));
      if (i % 2 == 0) exp_g(1'b0, 1'b1, 6'(40 + i), 14'(14'h050 + i), 14'd0, 1'b0);
      else            exp_g(1'b1, 1'b1, 6'(48 + i), 14'(14'h060 + i), 14'd0, 1'b0);
      step();
    end
    idle_all();
    step();
`endif

    // Reset right after a granted read drops the pending return and clears the pointer.
    drv0(1'b1, 1'b0, 1'b0, 6'd3, 14'd0);
    exp_g(1'b0, 1'b0, 6'd3, 14'd0, 14'd0, 1'b0);
    step();
    chk("rvalid_pre_rst", 32'(bus.r0_rvalid), 32'd1);
    rstn = 1'b0;
    idle_all();
    #1;
    chk_all_zero("midrst");
    step();
    rstn = 1'b1;
    drv0(1'b1, 1'b0, 1'b0, 6'd5, 14'd0);
    drv1(1'b1, 1'b0, 1'b0, 6'd9, 14'd0);
    exp_g(1'b0, 1'b0, 6'd5, 14'd0, 14'h2005, 1'b1);
    step();
    idle_all();
    step();
    step();

    chk("gnt_queue_empty", 32'(gq.size()), 32'd0);
    chk("read_queue_empty", 32'(rq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
